program_loader: RTL and testbench

//  Boot-time loader sitting upstream of the 8-bit CPU.
//  - Receives a framed byte stream (length, payload, checksum) over valid/ready.
//  - Writes the payload into the CPU instruction memory from address 0.
//  - Holds the CPU in reset until a verified image is in place.
//  - Reports success, or an error code, on checksum mismatch or inter-byte timeout.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/loader_timeout.sv | 40 ++++
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, loader state encoding and loader error codes.
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle counter; expired fires on the TIMEOUT-th idle cycle.
`default_nettype none

module loader_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_counter
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      logic [CNT_W-1:0] count;

      // Combinational expiry lets the FSM leave on the same edge the count would reach TIMEOUT.
      assign expired = en & ~clr & (count == CNT_W'(TIMEOUT - 1));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count <= '0;
        end else if (clr) begin
          count <= '0;
        end else if (en && !expired) begin
          count <= count + 1'b1;
        end
      end
    end else begin : g_disabled
      logic unused_ports;
      assign unused_ports = &{1'b0, clk, reset, clr, en};
      assign expired      = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// program_loader: receives a length/payload/checksum frame, writes it to
// instruction memory from address 0 and releases the CPU once verified.
`default_nettype none

module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam int REM_W = ADDR_W + 1;

  loader_state_t     state;
  loader_state_t     state_next;
  logic [REM_W-1:0]  remaining;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W-1:0] wr_addr;
  logic              active;
  logic              accept;
  logic              expired;
  logic              set_err;
  logic [1:0]        err_val;

  assign active    = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign in_ready  = active;
  assign accept    = in_valid & in_ready;
  assign cpu_hold  = (state != ST_DONE);
  assign load_done = (state == ST_DONE);
  assign load_err  = (state == ST_ERROR);

  // Held clear outside the loading states, which also covers entry to LEN.
  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept | ~active),
    .en      (active),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    err_val    = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LEN;
      end
      ST_LEN: begin
        if (accept) begin
          state_next = ST_DATA;
        end else if (expired) begin
          state_next = ST_ERROR;
          set_err    = 1'b1;
          err_val    = ERR_TIMEOUT;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (remaining == REM_W'(1)) state_next = ST_CSUM;
        end else if (expired) begin
          state_next = ST_ERROR;
          set_err    = 1'b1;
          err_val    = ERR_TIMEOUT;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (in_data == sum) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ERROR;
            set_err    = 1'b1;
            err_val    = ERR_CSUM;
          end
        end else if (expired) begin
          state_next = ST_ERROR;
          set_err    = 1'b1;
          err_val    = ERR_TIMEOUT;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) state_next = ST_LEN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      remaining <= '0;
      sum       <= '0;
      wr_addr   <= '0;
      err_code  <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;

      if (set_err) begin
        err_code <= err_val;
      end else if (!active && state_next == ST_LEN) begin
        err_code <= ERR_NONE;
      end

      if (accept) begin
        case (state)
          ST_LEN: begin
            // A length byte of zero denotes a full-memory image.
            remaining <= (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : REM_W'(in_data);
            sum       <= '0;
            wr_addr   <= '0;
          end
          ST_DATA: begin
            sum       <= sum + in_data;
            remaining <= remaining - 1'b1;
            wr_addr   <= wr_addr + 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven vectors plus directed multi-cycle sequences.
`default_nettype none

module tb_program_loader;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [1:0] err_code;

  int nvec = 0;
  int nmis = 0;

  program_loader #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Instruction-memory model fed by the write port, sampled mid-cycle.
  logic [7:0] img [256];
  int         wr_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      img[mem_addr] = mem_wdata;
      wr_cnt++;
    end
  end

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       rdy;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       hold;
    logic       done;
    logic       err;
    logic [1:0] code;
  } vec_t;

  vec_t tbl [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, err_code};
  endfunction

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int         base;
    int         bad;
    logic [7:0] bp [5];

    //           start valid data  | rdy we addr   wdata  hold done err code
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[2]  = '{1'b0, 1'b1, 8'h21, 1'b1, 1'b1, 8'h00, 8'h21, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 8'h35, 1'b1, 1'b1, 8'h01, 8'h35, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 8'hE0, 1'b1, 1'b1, 8'h02, 8'hE0, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[5]  = '{1'b0, 1'b1, 8'h36, 1'b0, 1'b0, 8'h02, 8'hE0, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h02, 8'hE0, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 8'hE0, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[8]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h02, 8'hE0, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 8'h01, 8'h20, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[11] = '{1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h01, 8'h20, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[12] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h01, 8'h20, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h20, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[14] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'h01, 8'h20, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h20, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[16] = '{1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[17] = '{1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0, 2'b00};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0, 2'b00};

    // Reset state, including a spurious valid while held in reset.
    in_valid = 1'b1;
    in_data  = 8'hAB;
    step();
    step();
    check("reset_outs", 32'(outs()), 32'({1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00}));
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check("idle_outs", 32'(outs()), 32'({1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00}));

    // Nominal load, bad checksum, ignored start in DATA/CSUM.
    for (int i = 0; i < 19; i++) begin
      start    = tbl[i].start;
      in_valid = tbl[i].valid;
      in_data  = tbl[i].data;
      step();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                 tbl[i].hold, tbl[i].done, tbl[i].err, tbl[i].code}));
    end
    start    = 1'b0;
    in_valid = 1'b0;

    // Length byte 0: full 256-byte image, checksum of 0..255 is 0x80.
    base  = wr_cnt;
    start = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h00;
    step();
    for (int i = 0; i < 256; i++) begin
      in_data = i[7:0];
      step();
    end
    in_data = 8'h80;
    step();
    in_valid = 1'b0;
    check("len0_wr_count", wr_cnt - base, 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (img[i] !== i[7:0]) bad++;
    check("len0_image_bad", bad, 0);
    check("len0_end", 32'({mem_we, mem_addr, load_done, cpu_hold, err_code}),
          32'({1'b0, 8'hFF, 1'b1, 1'b0, 2'b00}));

    // Inter-byte timeout: ERROR(10) lands exactly 16 cycles after the AA accept.
    start = 1'b1;
    step();
    start = 1'b0;
    send(8'h02);
    send(8'hAA);
    check("to_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 8'h00, 8'hAA}));
    repeat (15) step();
    check("to_not_yet", 32'({load_err, in_ready}), 32'({1'b0, 1'b1}));
    step();
    check("to_err", 32'({load_err, err_code, cpu_hold, in_ready, load_done}),
          32'({1'b1, 2'b10, 1'b1, 1'b0, 1'b0}));
    start = 1'b1;
    step();
    start = 1'b0;
    check("to_restart", 32'({load_err, err_code, in_ready}), 32'({1'b0, 2'b00, 1'b1}));
    send(8'h01);
    send(8'h5A);
    send(8'h5A);
    check("to_reload", 32'({load_done, load_err, err_code, cpu_hold, img[0]}),
          32'({1'b1, 1'b0, 2'b00, 1'b0, 8'h5A}));

    // Backpressure: random idle gaps shorter than TIMEOUT.
    bp   = '{8'h03, 8'hC3, 8'h5A, 8'h0F, 8'h2C};
    base = wr_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 8)) step();
      send(bp[i]);
    end
    step();
    check("bp_wr_count", wr_cnt - base, 3);
    check("bp_image", 32'({img[0], img[1], img[2]}), 32'({8'hC3, 8'h5A, 8'h0F}));
    check("bp_status", 32'({load_done, load_err, cpu_hold, err_code}),
          32'({1'b1, 1'b0, 1'b0, 2'b00}));

    // Abort with reset while a DATA write is in flight.
    start = 1'b1;
    step();
    start = 1'b0;
    send(8'h05);
    send(8'h11);
    send(8'h22);
    base  = wr_cnt;
    reset = 1'b1;
    #1;
    check("abort_now", 32'({mem_we, cpu_hold, in_ready}), 32'({1'b0, 1'b1, 1'b0}));
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();
    check("abort_writes", wr_cnt - base, 0);
    check("abort_idle", 32'(outs()), 32'({1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00}));
    in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
